// File: rtl/microcode_sequencer.sv
// Microcode step sequencer: latches opcode/flags, forms the ROM address {flags, opcode, step}
// and forwards the ROM word as the control word. Define MICROSEQ_STEP_TRAP_EN for the runaway-step trap.
module microcode_sequencer #(
  parameter int                      INSTR_WIDTH = 8,
  parameter int                      STEP_WIDTH  = 3,
  parameter int                      FLAG_WIDTH  = 4,
  parameter int                      CTRL_WIDTH  = 24,
  parameter int                      FINISH_BIT  = 20,
  parameter logic [CTRL_WIDTH-1:0]   IDLE_CTRL   = 24'h1FFFFF,
  parameter int                      COUNT_WIDTH = 16
) (
  input  logic                                      i_clk,
  input  logic                                      i_reset,
  input  logic [INSTR_WIDTH-1:0]                    i_instrCode,
  input  logic [FLAG_WIDTH-1:0]                     i_flags,
  input  logic                                      i_halt,
  input  logic                                      i_singleStepMode,
  input  logic                                      i_stepReq,
  input  logic [CTRL_WIDTH-1:0]                     i_decodeData,
  output logic [FLAG_WIDTH+INSTR_WIDTH+STEP_WIDTH-1:0] o_decodeAddr,
  output logic [CTRL_WIDTH-1:0]                     o_ctrl,
  output logic [INSTR_WIDTH-1:0]                    o_instr,
  output logic [STEP_WIDTH-1:0]                     o_step,
  output logic                                      o_paused,
  output logic                                      o_instrDone,
  output logic [COUNT_WIDTH-1:0]                    o_instrCount,
  output logic                                      o_trap
);

  localparam logic [STEP_WIDTH-1:0]  STEP_ONE  = {{(STEP_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PAUSE = 2'd1,
    ST_TRAP  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [STEP_WIDTH-1:0]   step_q,  step_d;
  logic [FLAG_WIDTH-1:0]   flags_q, flags_d;
  logic [INSTR_WIDTH-1:0]  instr_q, instr_d;
  logic [COUNT_WIDTH-1:0]  count_q, count_d;
  logic                    done_q,  done_d;

  logic run_active;
  logic finish;

  // Halt freezes the sequencer and masks the ROM word; finish is only seen while actually running.
  assign run_active = (state_q == ST_RUN) && !i_halt;
  assign finish     = run_active && !i_decodeData[FINISH_BIT];

`ifdef MICROSEQ_STEP_TRAP_EN
  logic runaway;
  logic trap_q, trap_d;

  assign runaway = run_active && !finish && (step_q == {STEP_WIDTH{1'b1}});
  assign trap_d  = trap_q | runaway;
`endif

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_RUN;
      step_q  <= '0;
      flags_q <= '0;
      instr_q <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
`ifdef MICROSEQ_STEP_TRAP_EN
      trap_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      flags_q <= flags_d;
      instr_q <= instr_d;
      count_q <= count_d;
      done_q  <= done_d;
`ifdef MICROSEQ_STEP_TRAP_EN
      trap_q  <= trap_d;
`endif
    end
  end

  // Next-state logic
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (finish) begin
          state_d = i_singleStepMode ? ST_PAUSE : ST_RUN;
        end
`ifdef MICROSEQ_STEP_TRAP_EN
        else if (runaway) begin
          state_d = ST_TRAP;
        end
`endif
      end
      ST_PAUSE: begin
        if ((i_stepReq || !i_singleStepMode) && !i_halt) begin
          state_d = ST_RUN;
        end
      end
`ifdef MICROSEQ_STEP_TRAP_EN
      ST_TRAP: state_d = ST_TRAP;
`endif
      default: state_d = ST_RUN;
    endcase
  end

  // Step, flag, opcode and retirement bookkeeping
  always_comb begin
    step_d  = step_q;
    flags_d = flags_q;
    instr_d = instr_q;
    count_d = count_q;
    done_d  = finish;
    if (!i_halt) begin
      case (state_q)
        ST_RUN: begin
          instr_d = i_instrCode;
          if (finish) begin
            step_d  = '0;
            flags_d = '0;
            count_d = count_q + COUNT_ONE;
          end else begin
            // The all-ones step wraps to 0 here, which is also the parked step after a trap.
            step_d  = step_q + STEP_ONE;
            flags_d = i_flags;
          end
        end
        ST_PAUSE: instr_d = i_instrCode;
        default: ;
      endcase
    end
  end

  // Output logic
  always_comb begin
    o_ctrl   = run_active ? i_decodeData : IDLE_CTRL;
    o_paused = (state_q == ST_PAUSE);
  end

  assign o_decodeAddr = {flags_q, instr_q, step_q};
  assign o_instr      = instr_q;
  assign o_step       = step_q;
  assign o_instrDone  = done_q;
  assign o_instrCount = count_q;

`ifdef MICROSEQ_STEP_TRAP_EN
  assign o_trap = trap_q;
`else
  assign o_trap = 1'b0;
`endif

endmodule

// File: tb/tb_microcode_sequencer.sv
// Scoreboarded bench for microcode_sequencer: a driver advances a behavioural model and queues
// expectations; a monitor compares every cycle. Honours MICROSEQ_STEP_TRAP_EN like the design.
module tb_microcode_sequencer;

  localparam logic [23:0] IDLE = 24'h1FFFFF;
`ifdef MICROSEQ_STEP_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, halt, single_step, step_req;
  logic [7:0]  instr_code;
  logic [3:0]  flags;
  logic [23:0] decode_data;
  logic [14:0] decode_addr;
  logic [23:0] ctrl;
  logic [7:0]  instr;
  logic [2:0]  step;
  logic        paused, instr_done, trap;
  logic [15:0] instr_count;

  always #5 clk = ~clk;

  microcode_sequencer dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_instrCode      (instr_code),
    .i_flags          (flags),
    .i_halt           (halt),
    .i_singleStepMode (single_step),
    .i_stepReq        (step_req),
    .i_decodeData     (decode_data),
    .o_decodeAddr     (decode_addr),
    .o_ctrl           (ctrl),
    .o_instr          (instr),
    .o_step           (step),
    .o_paused         (paused),
    .o_instrDone      (instr_done),
    .o_instrCount     (instr_count),
    .o_trap           (trap)
  );

  typedef struct {
    bit          valid;
    logic [23:0] ctrl;
    logic [2:0]  step;
    logic [7:0]  instr;
    logic [3:0]  flags;
    logic [15:0] count;
    logic        done;
    logic        paused;
    logic        trap;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  bit   drv_done = 1'b0;

  // Behavioural model: sequencer mode as two flags, counters as plain integers
  bit m_known = 1'b0;
  bit m_paused, m_trapped, m_trap, m_done;
  int m_step, m_flags, m_instr, m_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // One clock cycle of stimulus; fin=1 makes the ROM word carry the active-low finish marker.
  task automatic drive(input bit rst, input bit hlt, input bit ss, input bit sreq,
                       input logic [7:0] ins, input logic [3:0] fl, input bit fin);
    exp_t        e;
    logic [31:0] r;
    logic [23:0] dd;
    bit          f;
    @(negedge clk);
    r  = $urandom();
    dd = r[23:0];
    dd[20] = !fin;
    reset = rst; halt = hlt; single_step = ss; step_req = sreq;
    instr_code = ins; flags = fl; decode_data = dd;

    e.valid  = m_known;
    e.ctrl   = (!m_paused && !m_trapped && !hlt) ? dd : IDLE;
    e.step   = 3'(m_step);
    e.instr  = 8'(m_instr);
    e.flags  = 4'(m_flags);
    e.count  = 16'(m_count);
    e.done   = m_done;
    e.paused = m_paused;
    e.trap   = m_trap;
    q.push_back(e);

    f = !m_paused && !m_trapped && !hlt && fin;
    if (rst) begin
      m_known = 1'b1; m_paused = 1'b0; m_trapped = 1'b0; m_trap = 1'b0; m_done = 1'b0;
      m_step = 0; m_flags = 0; m_instr = 0; m_count = 0;
    end else begin
      m_done = f;
      if (!hlt && !m_trapped) begin
        m_instr = int'(ins);
        if (m_paused) begin
          if (sreq || !ss) m_paused = 1'b0;
        end else if (f) begin
          m_step = 0; m_flags = 0; m_count = (m_count + 1) % 65536;
          m_paused = ss;
        end else begin
          if (TRAP_EN && m_step == 7) begin
            m_trapped = 1'b1; m_trap = 1'b1;
          end
          m_step = (m_step + 1) % 8; m_flags = int'(fl);
        end
      end
    end
  endtask

  // Monitor: compares each queued expectation with the outputs settled after the last edge
  initial begin
    exp_t e;
    int   cycles = 0;
    forever begin
      @(negedge clk);
      #2;
      cycles++;
      if (cycles > 20000) begin
        n_total++;
        $display("FAIL timeout: monitor ran %0d cycles, required at most 20000", cycles);
        break;
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.valid) begin
          check("ctrl",       32'(ctrl),        32'(e.ctrl));
          check("step",       32'(step),        32'(e.step));
          check("instr",      32'(instr),       32'(e.instr));
          check("decode_addr", 32'(decode_addr), 32'({e.flags, e.instr, e.step}));
          check("instr_count", 32'(instr_count), 32'(e.count));
          check("instr_done", 32'(instr_done),  32'(e.done));
          check("paused",     32'(paused),      32'(e.paused));
          check("trap",       32'(trap),        32'(e.trap));
        end
      end else if (drv_done) begin
        break;
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Stimulus: directed scenarios first, then a long randomized run
  initial begin
    logic [31:0] r;
    bit          ss;
    reset = 1'b1; halt = 1'b0; single_step = 1'b0; step_req = 1'b0;
    instr_code = '0; flags = '0; decode_data = IDLE;
    drive(1, 0, 0, 0, 8'h00, 4'h0, 0);

    // Opcode 12: four busy steps, finish at step 4
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 8'h12, 4'h0, 0);
    drive(0, 0, 0, 0, 8'h12, 4'h0, 1);

    // Halt at step 2 for three cycles, then finish
    for (int i = 0; i < 2; i++) drive(0, 0, 0, 0, 8'h34, 4'h0, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 8'h35, 4'h3, i == 1);
    drive(0, 0, 0, 0, 8'h34, 4'h0, 0);
    drive(0, 0, 0, 0, 8'h34, 4'h0, 1);

    // Flags captured at step 0, cleared by finish
    drive(0, 0, 0, 0, 8'h56, 4'b0101, 0);
    drive(0, 0, 0, 0, 8'h56, 4'b0101, 0);
    drive(0, 0, 0, 0, 8'h56, 4'b1010, 1);

    // Single-step: pause, hold five cycles, release one instruction, pause again
    drive(0, 0, 1, 0, 8'h78, 4'h1, 0);
    drive(0, 0, 1, 0, 8'h78, 4'h1, 1);
    for (int i = 0; i < 5; i++) drive(0, 0, 1, 0, 8'h79, 4'h2, i[0]);
    drive(0, 0, 1, 1, 8'h7A, 4'h0, 0);
    drive(0, 0, 1, 0, 8'h7A, 4'h4, 0);
    drive(0, 0, 1, 0, 8'h7A, 4'h4, 1);
    drive(0, 0, 1, 0, 8'h7B, 4'h0, 0);
    drive(0, 0, 1, 0, 8'h7B, 4'h0, 1);

    // Leave pause and never finish: wrap or trap
    for (int i = 0; i < 12; i++) drive(0, 0, 0, 0, 8'h9A, 4'(i), 0);
    drive(0, 0, 0, 0, 8'h9A, 4'h0, 1);
    drive(1, 0, 0, 0, 8'h9A, 4'h0, 0);

    // Reach count 5, pause, then reset while paused
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 8'hA0, 4'h0, 1);
    drive(0, 0, 1, 0, 8'hA1, 4'h0, 1);
    drive(0, 0, 1, 0, 8'hA2, 4'h0, 0);
    drive(1, 0, 1, 0, 8'hA3, 4'h0, 0);
    drive(0, 0, 0, 0, 8'hA4, 4'h0, 0);

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      r  = $urandom();
      ss = ((i / 150) % 2) == 1;
      drive(r[6:0] == 7'd0, r[9:7] == 3'd0, ss, r[12:10] == 3'd0,
            r[20:13], r[24:21], r[26:25] == 2'd0);
    end
    drv_done = 1'b1;
  end

endmodule
